// File: rtl/buffer_stream_reader.sv
// Streams a circular region of memory through a single-outstanding word reader
// into a small output FIFO with valid/ready handshake.
module buffer_stream_reader #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned BUF_SIZE   = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_offset,
    input  logic [15:0]       word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              rd_request,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_done,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] PTR_MASK  = ADDR_W'(BUF_SIZE - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        ABORT
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_inc;
    logic [ADDR_W-1:0]   start_ptr;
    logic [15:0]         issue_left;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr_inc;
    logic [PTR_W-1:0]    rd_ptr_inc;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [DATA_W-1:0]   head_nxt;
    logic                flush;
    logic                push;
    logic                pop;
    logic                has_room;

    // FIFO next-state and buffer pointer arithmetic
    always_comb begin
        wr_ptr_inc = (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
        rd_ptr_inc = (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_W'(1);
        flush      = (state == ABORT) || (((state == RUN) || (state == DRAIN)) && abort);
        push       = rd_done && rd_request && !flush;
        pop        = out_valid && out_ready;
        rd_ptr_nxt = pop ? rd_ptr_inc : rd_ptr;
        count_nxt  = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = count - CNT_W'(1);
        end
        // A write into the slot that becomes head bypasses the array
        head_nxt   = (push && (wr_ptr == rd_ptr_nxt)) ? rd_data : mem[rd_ptr_nxt];
        has_room   = count_nxt < FULL_CNT;
        ptr_inc    = (ptr + ADDR_W'(1)) & PTR_MASK;
        start_ptr  = start_offset & PTR_MASK;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rd_data;
        end
    end

    // Output FIFO bookkeeping; head word is held in a register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_inc;
            end
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                out_data <= head_nxt;
            end
        end
    end

    // Transfer control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            issue_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            rd_request <= 1'b0;
            rd_addr    <= BASE;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;

            if (rd_done && rd_request) begin
                ptr     <= ptr_inc;
                rd_addr <= BASE + ptr_inc;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= RUN;
                            busy       <= 1'b1;
                            issue_left <= word_count;
                            ptr        <= start_ptr;
                            rd_addr    <= BASE + start_ptr;
                            rd_request <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= ABORT;
                        if (rd_request && rd_done) begin
                            rd_request <= 1'b0;
                        end
                    end else if (rd_request) begin
                        if (rd_done) begin
                            issue_left <= issue_left - 16'd1;
                            if (issue_left == 16'd1) begin
                                state      <= DRAIN;
                                rd_request <= 1'b0;
                            end else begin
                                rd_request <= has_room;
                            end
                        end
                    end else if ((issue_left != 16'd0) && has_room) begin
                        rd_request <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= ABORT;
                    end else if (count == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ABORT: begin
                    if (!rd_request || rd_done) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        rd_request <= 1'b0;
                        aborted    <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    rd_request <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Directed bench for buffer_stream_reader with a 4-cycle word-reader model
// and a monitor logging read addresses, delivered words and pulses.
module tb_buffer_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_offset = '0;
    logic [15:0] word_count = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        rd_request;
    logic [15:0] rd_addr;
    logic        rd_done;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [15:0] addr_q[$];
    logic [15:0] recv_q[$];
    int          done_cnt = 0;
    int          abort_cnt = 0;
    int          occ = 0;
    int          max_occ = 0;
    bit          req_seen = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_done = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [1:0]  lat = '0;

    buffer_stream_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_offset (start_offset),
        .word_count   (word_count),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .rd_request   (rd_request),
        .rd_addr      (rd_addr),
        .rd_done      (rd_done),
        .rd_data      (rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Word reader: answers each request after 4 cycles with data A000^addr
    always @(posedge clk) begin
        rd_done <= 1'b0;
        if (rst) begin
            lat     <= '0;
            rd_data <= '0;
        end else if (rd_request && !rd_done) begin
            if (lat == 2'd3) begin
                rd_done <= 1'b1;
                rd_data <= 16'hA000 ^ rd_addr;
                lat     <= '0;
            end else begin
                lat <= lat + 2'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_req && !prev_done) begin
                check("req_hold", {15'd0, rd_request}, 32'd1);
                check("addr_hold", {16'd0, rd_addr}, {16'd0, prev_addr});
            end
            if (rd_done) begin
                addr_q.push_back(rd_addr);
                occ++;
            end
            if (out_valid && out_ready) begin
                recv_q.push_back(out_data);
                occ--;
            end
            if (occ > max_occ) max_occ = occ;
            if (done) done_cnt++;
            if (aborted) abort_cnt++;
            if (rd_request) req_seen = 1'b1;
            prev_req  = rd_request;
            prev_done = rd_done;
            prev_addr = rd_addr;
        end
    end

    task automatic clear_log();
        addr_q.delete();
        recv_q.delete();
        done_cnt  = 0;
        abort_cnt = 0;
        occ       = 0;
        max_occ   = 0;
        req_seen  = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] off, input logic [15:0] wc);
        start_offset = off;
        word_count   = wc;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_seq(input string tag, input int n, input logic [15:0] first);
        logic [15:0] a;
        check({tag, "_nreads"}, 32'(addr_q.size()), 32'(n));
        check({tag, "_nwords"}, 32'(recv_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = (first + 16'(i)) & 16'h00FF;
            check({tag, "_addr"}, {16'd0, (i < addr_q.size()) ? addr_q[i] : 16'hDEAD}, {16'd0, a});
            check({tag, "_data"}, {16'd0, (i < recv_q.size()) ? recv_q[i] : 16'hDEAD},
                  {16'd0, 16'hA000 ^ a});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
        check({tag, "_rd_request"}, {31'd0, rd_request}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rd_addr"}, {16'd0, rd_addr}, 32'd0);
        check({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    endtask

    task automatic run_basic(input string tag);
        int n = 0;
        clear_log();
        out_ready = 1'b1;
        pulse_start(16'd5, 16'd3);
        check({tag, "_req_latency"}, {31'd0, rd_request}, 32'd1);
        check({tag, "_first_addr"}, {16'd0, rd_addr}, 32'd5);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        pulse_start(16'd100, 16'd9);
        while (!rd_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rd_done_seen"}, {31'd0, rd_done}, 32'd1);
        @(negedge clk);
        check({tag, "_valid_latency"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_first_word"}, {16'd0, out_data}, 32'h0000A005);
        wait_idle(tag, 100);
        check_seq(tag, 3, 16'd5);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic transfer, plus a start while busy that must be ignored
        run_basic("basic");

        // Pointer wrap at the end of the region
        clear_log();
        pulse_start(16'd254, 16'd4);
        wait_idle("wrap", 100);
        check_seq("wrap", 4, 16'd254);
        check("wrap_done_cnt", 32'(done_cnt), 32'd1);

        // Back-pressure: only FIFO_DEPTH reads may complete while the sink stalls
        clear_log();
        out_ready = 1'b0;
        pulse_start(16'd0, 16'd10);
        repeat (40) @(negedge clk);
        check("bp_reads", 32'(addr_q.size()), 32'd4);
        check("bp_req_low", {31'd0, rd_request}, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head", {16'd0, out_data}, 32'h0000A000);
        out_ready = 1'b1;
        wait_idle("bp", 200);
        check_seq("bp", 10, 16'd0);
        check("bp_no_overflow", {31'd0, (max_occ <= 4)}, 32'd1);
        check("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Abort with words buffered and a read outstanding
        clear_log();
        out_ready = 1'b0;
        pulse_start(16'd0, 16'd5);
        n = 0;
        while (addr_q.size() < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("abort_pre_reads", 32'(addr_q.size()), 32'd2);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("abort_req_held", {31'd0, rd_request}, 32'd1);
        check("abort_flushed", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        wait_idle("abort", 50);
        abort = 1'b0;
        check("abort_pulse_cnt", 32'(abort_cnt), 32'd1);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_reads", 32'(addr_q.size()), 32'd3);
        check("abort_no_words", 32'(recv_q.size()), 32'd0);
        check("abort_req_low", {31'd0, rd_request}, 32'd0);
        check("abort_valid_low", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // Abort while idle is ignored
        clear_log();
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_abort_busy", {31'd0, busy}, 32'd0);
        check("idle_abort_pulse", 32'(abort_cnt), 32'd0);
        abort = 1'b0;
        @(negedge clk);

        // Zero-length transfer
        clear_log();
        pulse_start(16'd7, 16'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("zero_done_pulse", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        check("zero_no_req", {31'd0, req_seen}, 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd1);

        // Reset in the middle of a transfer, then a fresh transfer
        clear_log();
        pulse_start(16'd0, 16'd8);
        repeat (6) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_basic("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
